// File: rtl/dii_package.sv
// Shared DII flit types: a flit is {last, first, data}, stored as one packed word.
package dii_package;
  localparam int DII_FLIT_WIDTH = 16;

  typedef struct packed {
    logic                      last;
    logic                      first;
    logic [DII_FLIT_WIDTH-1:0] data;
  } dii_flit;
endpackage

// File: rtl/osd_dii_packet_buffer.sv
// Store-and-forward (or cut-through) FIFO for DII flits between a debug module and its ring port.
// Output is a registered-write / combinational-read view of mem[rd_ptr]; one cycle min latency.
module osd_dii_packet_buffer
  import dii_package::*;
#(
  parameter int WIDTH      = DII_FLIT_WIDTH,
  parameter int DEPTH      = 8,
  parameter int FULLPACKET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

  dii_flit         mem [DEPTH];
  dii_flit         rd_flit;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     count;
  logic [AW:0]     pkts;
  logic            push;
  logic            pop;
  logic            pkt_inc;
  logic            pkt_dec;

  // Store-and-forward only offers data once a complete packet (a stored last) is present.
  assign in_ready  = ~rst & (count != CNT_FULL);
  assign out_valid = (count != '0) & ((FULLPACKET == 0) | (pkts != '0));

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign pkt_inc = push & in_last;
  assign pkt_dec = pop & rd_flit.last;

  assign rd_flit   = mem[rd_ptr];
  assign out_data  = rd_flit.data;
  assign out_first = rd_flit.first;
  assign out_last  = rd_flit.last;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{last: in_last, first: in_first, data: in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      pkts   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      unique case ({pkt_inc, pkt_dec})
        2'b10:   pkts <= pkts + CNT_ONE;
        2'b01:   pkts <= pkts - CNT_ONE;
        default: pkts <= pkts;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A full buffer with no complete packet can never drain: packet longer than DEPTH.
  always_ff @(posedge clk) begin
    if (!rst && FULLPACKET != 0) begin
      assert (!(count == CNT_FULL && pkts == '0))
        else $error("packet longer than buffer depth in store-and-forward mode");
    end
  end
`endif
endmodule
